// File: rtl/aes_ctr_feeder.sv
// aes_ctr_feeder: counter-mode block generator feeding a pipelined AES encryptor.
// Issues {iv, ctr} blocks at up to one per cycle, gated by credits that mirror
// free space in the downstream keystream FIFO, and tracks blocks in flight so
// that done is reported only after the last block has left the AES pipeline.
//
// Ports:
//   CLK, RSTn      clock (rising edge), asynchronous active-low reset
//   start          one-cycle job request, sampled only in IDLE
//   abort          stop issuing, then drain blocks already in flight
//   iv, ctr_init   fixed upper part and first counter value of each block
//   n_blocks       number of blocks to issue for the job
//   credit_ret     downstream FIFO popped one entry
//   Dvld           AES pipeline output valid
//   Din, Drdy      block to the AES pipeline and its valid
//   busy           job active (ISSUE or DRAIN)
//   done           one-cycle job completion pulse
//   err            sticky credit / in-flight accounting error
//   inflight       blocks issued but not yet returned on Dvld
module aes_ctr_feeder #(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned CTR_W      = 64,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned IV_W      = 128 - CTR_W,
  localparam int unsigned INF_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  input  logic [IV_W-1:0]  iv,
  input  logic [CTR_W-1:0] ctr_init,
  input  logic [CNT_W-1:0] n_blocks,
  input  logic             credit_ret,
  input  logic             Dvld,
  output logic [127:0]     Din,
  output logic             Drdy,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [INF_W-1:0] inflight
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [INF_W-1:0] CREDIT_FULL = INF_W'(FIFO_DEPTH);

  state_t           state_q, state_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [INF_W-1:0] credit_q, credit_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [127:0]     din_q, din_d;
  logic             drdy_q, drdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             issue;

  // Next-state, datapath and accounting.
  always_comb begin
    state_d    = state_q;
    iv_d       = iv_q;
    ctr_d      = ctr_q;
    rem_d      = rem_q;
    credit_d   = credit_q;
    inflight_d = inflight_q;
    din_d      = din_q;
    drdy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    issue = (state_q == ISSUE) && (rem_q != '0) && (credit_q != '0) && !abort;

    if (issue) begin
      drdy_d = 1'b1;
      din_d  = {iv_q, ctr_q};
      ctr_d  = ctr_q + CTR_W'(1);
      rem_d  = rem_q - CNT_W'(1);
    end

    // Credit: simultaneous issue and return cancel; a return at full credit is an error.
    case ({issue, credit_ret})
      2'b10:   credit_d = credit_q - INF_W'(1);
      2'b01: begin
        if (credit_q == CREDIT_FULL) err_d = 1'b1;
        else                          credit_d = credit_q + INF_W'(1);
      end
      default: credit_d = credit_q;
    endcase

    // In flight: a Dvld with nothing outstanding is an error and does not underflow.
    case ({issue, Dvld})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01: begin
        if (inflight_q == '0) err_d = 1'b1;
        else                   inflight_d = inflight_q - INF_W'(1);
      end
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_blocks != '0) begin
            iv_d    = iv;
            ctr_d   = ctr_init;
            rem_d   = n_blocks;
            state_d = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort || (rem_d == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        // Uses the updated count so a same-cycle Dvld is taken into account.
        if (inflight_d == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      iv_q       <= '0;
      ctr_q      <= '0;
      rem_q      <= '0;
      credit_q   <= CREDIT_FULL;
      inflight_q <= '0;
      din_q      <= '0;
      drdy_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      iv_q       <= iv_d;
      ctr_q      <= ctr_d;
      rem_q      <= rem_d;
      credit_q   <= credit_d;
      inflight_q <= inflight_d;
      din_q      <= din_d;
      drdy_q     <= drdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign Din      = din_q;
  assign Drdy     = drdy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign inflight = inflight_q;

endmodule

// File: tb/tb_aes_ctr_feeder.sv
// Testbench for aes_ctr_feeder: AES pipeline modelled as a fixed-latency Dvld
// loopback, downstream FIFO pops modelled as credit_ret (tied to Dvld or manual).
// Expected blocks for each job are queued at start; a monitor checks every Drdy.
module tb_aes_ctr_feeder;
  localparam int unsigned LAT = 10;

  logic         CLK;
  logic         RSTn;
  logic         start;
  logic         abort;
  logic [63:0]  iv;
  logic [63:0]  ctr_init;
  logic [31:0]  n_blocks;
  logic         credit_ret = 1'b0;
  logic         Dvld = 1'b0;
  logic [127:0] Din;
  logic         Drdy;
  logic         busy;
  logic         done;
  logic         err;
  logic [5:0]   inflight;

  aes_ctr_feeder #(.FIFO_DEPTH(32), .CTR_W(64), .CNT_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort), .iv(iv),
    .ctr_init(ctr_init), .n_blocks(n_blocks), .credit_ret(credit_ret),
    .Dvld(Dvld), .Din(Din), .Drdy(Drdy), .busy(busy), .done(done),
    .err(err), .inflight(inflight)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0, nerr = 0;       // main-thread comparisons
  int mvec = 0, merr = 0;       // monitor comparisons
  logic [127:0] exp_q[$];       // expected blocks of the current job, in order
  int job_id = 0, mon_job = 0, job_cnt = 0;
  bit auto_cr = 1'b1;
  int cr_req = 0, cr_done = 0;
  logic [LAT-1:0] pipe = '0;

  // AES pipeline latency model and downstream FIFO pop model.
  always @(negedge CLK) begin
    if (!RSTn) begin
      pipe       = '0;
      Dvld       = 1'b0;
      credit_ret = 1'b0;
    end else begin
      pipe       = {pipe[LAT-2:0], Drdy};
      Dvld       = pipe[LAT-1];
      credit_ret = auto_cr & Dvld;
      if (cr_done < cr_req) begin
        credit_ret = 1'b1;
        cr_done++;
      end
    end
  end

  // Scoreboard monitor: each presented block must be the next expected one.
  always @(negedge CLK) begin
    if (RSTn && Drdy) begin
      if (job_id != mon_job) begin
        mon_job = job_id;
        job_cnt = 0;
      end
      mvec++;
      if (job_cnt >= exp_q.size()) begin
        merr++;
        $display("FAIL unexpected_drdy job %0d: got Din=%h, required no block", job_id, Din);
      end else if (Din !== exp_q[job_cnt]) begin
        merr++;
        $display("FAIL din job %0d blk %0d: got %h, required %h", job_id, job_cnt, Din, exp_q[job_cnt]);
      end
      job_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    end
  endtask

  // Reference: a job of n blocks yields {iv, ctr_init + i mod 2^64} for i = 0..n-1.
  task automatic run_start(input logic [63:0] iv_v, input logic [63:0] ctr_v, input int unsigned n);
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) exp_q.push_back({iv_v, ctr_v + 64'(i)});
    job_id++;
    iv       = iv_v;
    ctr_init = ctr_v;
    n_blocks = 32'(n);
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, inout int k, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge CLK);
      if (Drdy) k++;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int  k;
    int  c;
    bit  seen;
    int unsigned n;
    logic [63:0] iv_v, ctr_v;

    RSTn = 1'b0; start = 1'b0; abort = 1'b0;
    iv = '0; ctr_init = '0; n_blocks = '0;
    repeat (3) @(negedge CLK);
    chk("rst_din",      Din, 128'h0);
    chk("rst_drdy",     128'(Drdy), 128'h0);
    chk("rst_busy",     128'(busy), 128'h0);
    chk("rst_done",     128'(done), 128'h0);
    chk("rst_err",      128'(err), 128'h0);
    chk("rst_inflight", 128'(inflight), 128'h0);
    RSTn = 1'b1;
    @(negedge CLK);

    // Single block.
    k = 0;
    run_start(64'h0, 64'h0, 1);
    wait_done(100, k, seen);
    chk("single_done_seen", 128'(seen), 128'h1);
    chk("single_count",     128'(k), 128'h1);
    chk("single_busy",      128'(busy), 128'h0);
    chk("single_inflight",  128'(inflight), 128'h0);
    chk("single_err",       128'(err), 128'h0);
    @(negedge CLK);
    chk("single_done_pulse", 128'(done), 128'h0);

    // Burst of 4 at full rate.
    run_start(64'h0, 64'h10, 4);
    c = 0;
    while (!Drdy && c < 10) begin
      @(negedge CLK);
      c++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("burst_drdy_high", 128'(Drdy), 128'h1);
      @(negedge CLK);
    end
    chk("burst_drdy_low", 128'(Drdy), 128'h0);
    k = 0;
    wait_done(100, k, seen);
    chk("burst_done_seen", 128'(seen), 128'h1);

    // Counter wrap; iv untouched.
    k = 0;
    run_start(64'hA5, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    wait_done(100, k, seen);
    chk("wrap_done_seen", 128'(seen), 128'h1);
    chk("wrap_count",     128'(k), 128'h2);

    // Randomized jobs, some crossing the credit limit, some near wrap.
    for (int j = 0; j < 6; j++) begin
      iv_v  = {$urandom, $urandom};
      ctr_v = (j % 2 == 0) ? {$urandom, $urandom} : 64'h0 - 64'($urandom_range(1, 6));
      n     = $urandom_range(1, 45);
      k = 0;
      run_start(iv_v, ctr_v, n);
      wait_done(600, k, seen);
      chk("rand_done_seen", 128'(seen), 128'h1);
      chk("rand_count",     128'(k), 128'(n));
      chk("rand_inflight",  128'(inflight), 128'h0);
      chk("rand_busy",      128'(busy), 128'h0);
    end

    // Zero-length job: done on the next cycle, nothing issued.
    k = 0;
    run_start(64'h1, 64'h2, 0);
    chk("zero_done", 128'(done), 128'h1);
    chk("zero_busy", 128'(busy), 128'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (Drdy) k++;
    end
    chk("zero_count", 128'(k), 128'h0);

    // Abort after 5 blocks, then drain.
    run_start(64'h1234, 64'h100, 100);
    k = 0; c = 0;
    while (k < 5 && c < 50) begin
      @(negedge CLK);
      if (Drdy) k++;
      c++;
    end
    abort = 1'b1;
    chk("abort_reach5", 128'(k), 128'h5);
    @(negedge CLK);
    if (Drdy) k++;
    chk("abort_busy",     128'(busy), 128'h1);
    chk("abort_inflight", 128'(inflight), 128'h5);
    chk("abort_no_done",  128'(done), 128'h0);
    wait_done(200, k, seen);
    chk("abort_done_seen", 128'(seen), 128'h1);
    chk("abort_count",     128'(k), 128'h5);
    chk("abort_inflight0", 128'(inflight), 128'h0);
    abort = 1'b0;

    // Credit return at full credit sets err.
    chk("err_clear", 128'(err), 128'h0);
    cr_req = cr_req + 1;
    repeat (3) @(negedge CLK);
    chk("err_set", 128'(err), 128'h1);

    // Credit stall: only 32 blocks without returns, then 8 more.
    auto_cr = 1'b0;
    k = 0;
    run_start(64'hBEEF, 64'h0, 40);
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (Drdy) k++;
    end
    chk("stall_count32",  128'(k), 128'd32);
    chk("stall_busy",     128'(busy), 128'h1);
    chk("stall_inflight", 128'(inflight), 128'h0);
    cr_req = cr_req + 8;
    wait_done(200, k, seen);
    chk("stall_done_seen", 128'(seen), 128'h1);
    chk("stall_count40",   128'(k), 128'd40);
    chk("stall_err_sticky", 128'(err), 128'h1);
    auto_cr = 1'b1;

    // Reset mid-ISSUE.
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    k = 0; c = 0;
    run_start(64'h77, 64'h500, 50);
    while (k < 3 && c < 20) begin
      @(negedge CLK);
      if (Drdy) k++;
      c++;
    end
    #2 RSTn = 1'b0;
    #1;
    chk("mrst_drdy",     128'(Drdy), 128'h0);
    chk("mrst_busy",     128'(busy), 128'h0);
    chk("mrst_err",      128'(err), 128'h0);
    chk("mrst_inflight", 128'(inflight), 128'h0);
    chk("mrst_din",      Din, 128'h0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Drdy) k++;
    end
    chk("mrst_quiet", 128'(k), 128'h0);

    nvec = nvec + mvec;
    nerr = nerr + merr;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
